// File: rtl/instr_loader.sv
// Switch-bank instruction loader: debounced load/clear buttons assemble DATA_W beats
// into INSTR_W words and queue them in a DEPTH-entry FIFO. Define INSTR_LOADER_DEBOUNCE_EN to enable the debounce filter.
module instr_loader #(
    parameter int DATA_W       = 8,
    parameter int INSTR_W      = 16,
    parameter int DEPTH        = 4,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          sw_in,
    input  logic                       btn_load,
    input  logic                       btn_clear,
    output logic [INSTR_W-1:0]         instr_out,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       partial,
    output logic                       overflow
);

    localparam int BEATS  = INSTR_W / DATA_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PART_W = INSTR_W - DATA_W;

    if ((INSTR_W % DATA_W) != 0 || BEATS < 2 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYC < 1) begin : g_param_err
        $error("instr_loader: illegal parameter combination");
    end

    // ---------------- button conditioning: bit 0 = load, bit 1 = clear
    logic [1:0] w_btn;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;
    logic [1:0] r_armed;
    logic [1:0] r_vld;
    logic [1:0] w_filt;
    logic [1:0] w_evt;

    assign w_btn = {btn_clear, btn_load};

    // A button only arms once a genuine low has been seen after reset, so a
    // press held through reset release cannot fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_armed <= '0;
            r_vld   <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            r_prev  <= w_filt;
            r_armed <= r_armed | ({2{r_vld[1]}} & ~r_sync2 & ~w_filt);
        end
    end

`ifdef INSTR_LOADER_DEBOUNCE_EN
    localparam int DBC_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       r_filt;
    logic [DBC_W-1:0] r_dbc [2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                r_dbc[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_filt[b]) begin
                    r_dbc[b] <= '0;
                end else if (r_dbc[b] == DBC_W'(DEBOUNCE_CYC - 1)) begin
                    r_filt[b] <= r_sync2[b];
                    r_dbc[b]  <= '0;
                end else begin
                    r_dbc[b] <= r_dbc[b] + DBC_W'(1);
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    assign w_evt = w_filt & ~r_prev & r_armed;

    logic w_load_evt;
    logic w_clr_evt;

    assign w_clr_evt  = w_evt[1];
    assign w_load_evt = w_evt[0] & ~w_evt[1];

    // ---------------- beat assembly
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [PART_W-1:0] r_part;
    logic              r_partial;
    logic              w_last_beat;
    logic              w_push;
    logic [INSTR_W-1:0] w_word;

    assign w_last_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));
    assign w_push      = w_load_evt & w_last_beat;
    assign w_word      = {sw_in, r_part};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_part     <= '0;
            r_partial  <= 1'b0;
        end else if (w_clr_evt) begin
            r_beat_cnt <= '0;
            r_part     <= '0;
            r_partial  <= 1'b0;
        end else if (w_load_evt) begin
            if (w_last_beat) begin
                r_beat_cnt <= '0;
                r_partial  <= 1'b0;
            end else begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                r_partial  <= 1'b1;
                for (int unsigned b = 0; b < BEATS - 1; b++) begin
                    if (r_beat_cnt == BEAT_W'(b)) begin
                        r_part[b*DATA_W +: DATA_W] <= sw_in;
                    end
                end
            end
        end
    end

    // ---------------- FIFO
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_wr;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & instr_ready;
    // When full, the write lands in the slot being popped, which becomes the new tail.
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_clr_evt) begin
                r_ovf <= 1'b0;
            end else if (w_push && !w_wr) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign instr_out   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign instr_valid = ~w_empty;
    assign fifo_count  = r_count;
    assign partial     = r_partial;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_instr_loader.sv
// Directed + randomized bench for instr_loader against a queue-based reference model.
module tb_instr_loader;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;
    localparam int DBC     = 4;
`ifdef INSTR_LOADER_DEBOUNCE_EN
    localparam int LAT           = 6;
    localparam bit GLITCH_PASSES = 1'b0;
`else
    localparam int LAT           = 2;
    localparam bit GLITCH_PASSES = 1'b1;
`endif

    logic               clk;
    logic               rst_n;
    logic [DATA_W-1:0]  sw_in;
    logic               btn_load;
    logic               btn_clear;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;
    logic [2:0]         fifo_count;
    logic               partial;
    logic               overflow;

    instr_loader #(
        .DATA_W      (DATA_W),
        .INSTR_W     (INSTR_W),
        .DEPTH       (DEPTH),
        .DEBOUNCE_CYC(DBC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .btn_load   (btn_load),
        .btn_clear  (btn_clear),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fifo_count (fifo_count),
        .partial    (partial),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_fifo [$];
    logic [7:0]  m_beats [$];
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [15:0] e_out;
        e_out = (m_fifo.size() != 0) ? m_fifo[0] : 16'h0000;
        chk({tag, "/out"},      32'(instr_out),   32'(e_out));
        chk({tag, "/valid"},    32'(instr_valid), 32'(m_fifo.size() != 0));
        chk({tag, "/count"},    32'(fifo_count),  32'(m_fifo.size()));
        chk({tag, "/partial"},  32'(partial),     32'(m_beats.size() != 0));
        chk({tag, "/overflow"}, 32'(overflow),    32'(m_ovf));
    endtask

    // Reference: beats collect low-first; the second beat completes a word.
    function automatic void model_load(input logic [7:0] b);
        logic [15:0] word;
        if (m_beats.size() == 1) begin
            word = {b, m_beats[0]};
            m_beats.delete();
            if (m_fifo.size() < DEPTH) m_fifo.push_back(word);
            else m_ovf = 1'b1;
        end else begin
            m_beats.push_back(b);
        end
    endfunction

    function automatic void model_clear();
        m_beats.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_reset();
        m_beats.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
    endfunction

    task automatic press(input bit ld, input bit cl, input logic [7:0] v);
        @(negedge clk);
        sw_in = v; btn_load = ld; btn_clear = cl;
        repeat (10) @(negedge clk);
        btn_load = 1'b0; btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        if (cl) model_clear();
        else if (ld) model_load(v);
    endtask

    task automatic load_byte(input logic [7:0] v);
        press(1'b1, 1'b0, v);
    endtask

    task automatic glitch(input logic [7:0] v);
        @(negedge clk);
        sw_in = v; btn_load = 1'b1;
        repeat (2) @(negedge clk);
        btn_load = 1'b0;
        repeat (12) @(negedge clk);
        if (GLITCH_PASSES) model_load(v);
    endtask

    task automatic pop_one();
        @(negedge clk);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) begin
            chk_all(tag);
            pop_one();
        end
        chk_all({tag, "_empty"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; instr_ready = 1'b1; btn_load = 1'b0; btn_clear = 1'b0;
        model_reset();
        @(negedge clk);
        chk_all("in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1; instr_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk_all("post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] lo;
        logic [7:0] hi;
        int unsigned op;

        rst_n = 1'b0; sw_in = '0; btn_load = 1'b0; btn_clear = 1'b0; instr_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset with both buttons held high; no event until a fresh press.
        btn_load = 1'b1; btn_clear = 1'b1; instr_ready = 1'b1; sw_in = 8'hAA;
        repeat (3) @(negedge clk);
        chk_all("rst_hold");
        rst_n = 1'b1; instr_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk_all("held_after_rst");
        btn_load = 1'b0; btn_clear = 1'b0;
        repeat (12) @(negedge clk);
        chk_all("released");

        // Two-beat assembly.
        load_byte(8'h3A);
        chk_all("beat0");
        load_byte(8'hC5);
        chk("word_C53A", 32'(instr_out), 32'h0000_C53A);
        chk_all("word1");
        pop_one();
        chk_all("pop1");

        // Overflow on the fifth word, then drain in order with ready held.
        for (int w = 1; w <= 5; w++) begin
            load_byte(8'(w));
            load_byte(8'h00);
            chk_all("fill");
        end
        chk("ovf_set", 32'(overflow), 32'h1);
        @(negedge clk);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(instr_out), 32'(i + 1));
            chk_all("drain");
            @(negedge clk);
            void'(m_fifo.pop_front());
        end
        instr_ready = 1'b0;
        chk_all("drained");
        pop_one();
        chk_all("pop_empty");

        // Clear discards the partial beat and clears the sticky overflow.
        load_byte(8'h11);
        press(1'b0, 1'b1, 8'h00);
        chk_all("after_clear");
        load_byte(8'h22);
        load_byte(8'h33);
        chk("word_3322", 32'(instr_out), 32'h0000_3322);
        chk_all("after_3322");
        load_byte(8'h44);
        press(1'b1, 1'b1, 8'h99);
        chk_all("clr_and_load");
        load_byte(8'h55);
        load_byte(8'h66);
        chk_all("after_6655");
        drain("d39");

        // Short glitches on the load button.
        glitch(8'($urandom));
        chk_all("glitch1");
        glitch(8'($urandom));
        chk_all("glitch2");
        press(1'b0, 1'b1, 8'h00);
        drain("d40");

        // Final beat lands on the same edge as a pop while full.
        for (int w = 0; w < 4; w++) begin
            load_byte(8'($urandom));
            load_byte(8'($urandom));
        end
        lo = 8'($urandom);
        hi = 8'($urandom);
        load_byte(lo);
        chk_all("full_partial");
        @(negedge clk);
        sw_in = hi; btn_load = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_ready = 1'b0;
        void'(m_fifo.pop_front());
        model_load(hi);
        chk("same_cycle_count", 32'(fifo_count), 32'd4);
        chk("same_cycle_ovf", 32'(overflow), 32'd0);
        repeat (8) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        chk_all("push_pop_full");
        drain("d41");

        // Reset mid-assembly discards the held beat.
        load_byte(8'h7E);
        load_byte(8'h01);
        load_byte(8'hE7);
        chk_all("pre_reset");
        do_reset();
        load_byte(8'h5A);
        load_byte(8'hA5);
        chk("word_A55A", 32'(instr_out), 32'h0000_A55A);
        chk_all("post_reset_word");
        drain("d32");

        // Randomized mix of loads, pops and clears.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) load_byte(8'($urandom));
            else if (op <= 8) pop_one();
            else press(1'b0, 1'b1, 8'h00);
            chk_all("rand");
        end
        drain("d_rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
